// File: rtl/gige_pkg.sv
// Shared MDIO Clause 22 constants, controller state encoding and frame builder
// used by the PHY management controller.
package gige_pkg;

  localparam logic [1:0] MDIO_ST    = 2'b01;
  localparam logic [1:0] MDIO_OP_WR = 2'b01;
  localparam logic [1:0] MDIO_OP_RD = 2'b10;
  localparam logic [1:0] MDIO_TA_WR = 2'b10;

  localparam int PREAMBLE_LEN = 32;
  localparam int FRAME_LEN    = 32;
  localparam int TA_BIT0      = 14;  // first turnaround bit within the frame
  localparam int DATA_BIT0    = 16;

  typedef enum logic [2:0] {
    S_RST_ASSERT,
    S_STRAP_HOLD,
    S_IDLE,
    S_PREAMBLE,
    S_FRAME,
    S_TAIL
  } mgmt_state_e;

  typedef struct packed {
    logic        write;
    logic [4:0]  regad;
    logic [15:0] wdata;
  } mgmt_req_t;

  // Read frames carry ones in TA/data so mdio_o idles high while released.
  function automatic logic [31:0] mdio_frame(input logic [4:0] phy, input mgmt_req_t r);
    mdio_frame = {MDIO_ST,
                  r.write ? MDIO_OP_WR : MDIO_OP_RD,
                  phy,
                  r.regad,
                  r.write ? MDIO_TA_WR : 2'b11,
                  r.write ? r.wdata : 16'hFFFF};
  endfunction

endpackage

// File: rtl/mdio_clk_gen.sv
// MDC half-period divider: produces mdc plus one-cycle strobes on the clk_50
// edges where mdc rises and falls. Held low and cleared while disabled.
module mdio_clk_gen #(
  parameter int CLK_DIV = 10
) (
  input  logic clk_50,
  input  logic reset_n,
  input  logic en_i,
  output logic mdc_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          mdc_q, mdc_d;
  logic          half_done;

  assign half_done = en_i && (cnt_q == CW'(CLK_DIV - 1));
  assign rise_o    = half_done && !mdc_q;
  assign fall_o    = half_done && mdc_q;
  assign mdc_o     = mdc_q;

  always_comb begin
    cnt_d = cnt_q;
    mdc_d = mdc_q;
    if (!en_i) begin
      cnt_d = '0;
      mdc_d = 1'b0;
    end else if (half_done) begin
      cnt_d = '0;
      mdc_d = !mdc_q;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_50 or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
      mdc_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      mdc_q <= mdc_d;
    end
  end

endmodule

// File: rtl/phy_mgmt_ctrl.sv
// PHY bring-up (hardware reset + strap drive) followed by a Clause 22 MDIO
// master serving one register read/write request at a time.
module phy_mgmt_ctrl
  import gige_pkg::*;
#(
  parameter int         CLK_DIV    = 10,
  parameter int         RST_CYCLES = 500000,
  parameter int         STRAP_HOLD = 50,
  parameter logic [7:0] STRAP_VAL  = 8'h00,
  parameter logic [4:0] PHY_ADDR   = 5'd0
) (
  input  logic        clk_50,
  input  logic        reset_n,
  input  logic        rst_req,
  output logic        phy_hw_rst,
  output logic        strap_oe,
  output logic [7:0]  strap_out,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [4:0]  req_reg,
  input  logic [15:0] req_wdata,
  output logic        rsp_valid,
  output logic [15:0] rsp_rdata,
  output logic        rsp_err,
  output logic        mdc,
  output logic        mdio_o,
  output logic        mdio_oe,
  input  logic        mdio_i,
  output logic        phy_ready
);

  localparam int SEQ_MAX = (RST_CYCLES > STRAP_HOLD) ? RST_CYCLES : STRAP_HOLD;
  localparam int SEQ_W   = $clog2(SEQ_MAX + 1);

  mgmt_state_e state_q, state_d;
  logic [SEQ_W-1:0] seq_cnt_q, seq_cnt_d;
  logic [4:0]       bit_cnt_q, bit_cnt_d;
  logic             wr_q;
  logic [31:0]      frame_q;
  logic [15:0]      rd_shift_q;
  logic             ta_err_q;
  logic             mdio_o_q, mdio_oe_q;
  logic             rsp_valid_q, rsp_err_q;
  logic [15:0]      rsp_rdata_q;

  logic      mdc_en, mdc_rise, mdc_fall;
  logic      accept, last_bit;
  mgmt_req_t req_in;

  assign req_in   = {req_write, req_reg, req_wdata};
  assign accept   = (state_q == S_IDLE) && req_valid && !rst_req;
  assign last_bit = (bit_cnt_q == 5'(FRAME_LEN - 1));

  mdio_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
    .clk_50  (clk_50),
    .reset_n (reset_n),
    .en_i    (mdc_en),
    .mdc_o   (mdc),
    .rise_o  (mdc_rise),
    .fall_o  (mdc_fall)
  );

  always_ff @(posedge clk_50 or negedge reset_n) begin
    if (!reset_n) state_q <= S_RST_ASSERT;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_RST_ASSERT: if (seq_cnt_q == SEQ_W'(RST_CYCLES - 1)) state_d = S_STRAP_HOLD;
      S_STRAP_HOLD: if (seq_cnt_q == SEQ_W'(STRAP_HOLD - 1)) state_d = S_IDLE;
      S_IDLE: begin
        if (rst_req)        state_d = S_RST_ASSERT;
        else if (req_valid) state_d = S_PREAMBLE;
      end
      S_PREAMBLE:   if (mdc_fall && bit_cnt_q == 5'(PREAMBLE_LEN - 1)) state_d = S_FRAME;
      S_FRAME:      if (mdc_fall && last_bit) state_d = S_TAIL;
      S_TAIL:       if (mdc_fall) state_d = S_IDLE;
      default:      state_d = S_RST_ASSERT;
    endcase
  end

  always_comb begin
    phy_hw_rst = 1'b1;
    strap_oe   = 1'b0;
    req_ready  = 1'b0;
    phy_ready  = 1'b0;
    mdc_en     = 1'b0;
    unique case (state_q)
      S_RST_ASSERT: begin
        phy_hw_rst = 1'b0;
        strap_oe   = 1'b1;
      end
      S_STRAP_HOLD: strap_oe = 1'b1;
      S_IDLE: begin
        req_ready = 1'b1;
        phy_ready = 1'b1;
      end
      S_PREAMBLE, S_FRAME, S_TAIL: mdc_en = 1'b1;
      default: ;
    endcase
  end

  // Both counters restart on every state change, so neither can wrap.
  always_comb begin
    seq_cnt_d = '0;
    bit_cnt_d = '0;
    if (state_d == state_q) begin
      if (state_q == S_RST_ASSERT || state_q == S_STRAP_HOLD) seq_cnt_d = seq_cnt_q + 1'b1;
      bit_cnt_d = (mdc_en && mdc_fall) ? bit_cnt_q + 1'b1 : bit_cnt_q;
    end
  end

  always_ff @(posedge clk_50 or negedge reset_n) begin
    if (!reset_n) begin
      seq_cnt_q <= '0;
      bit_cnt_q <= '0;
    end else begin
      seq_cnt_q <= seq_cnt_d;
      bit_cnt_q <= bit_cnt_d;
    end
  end

  always_ff @(posedge clk_50 or negedge reset_n) begin
    if (!reset_n) begin
      wr_q        <= 1'b0;
      frame_q     <= '0;
      rd_shift_q  <= '0;
      ta_err_q    <= 1'b0;
      mdio_o_q    <= 1'b1;
      mdio_oe_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      rsp_valid_q <= 1'b0;
      if (accept) begin
        wr_q        <= req_write;
        frame_q     <= mdio_frame(PHY_ADDR, req_in);
        rd_shift_q  <= '0;
        ta_err_q    <= 1'b0;
        mdio_o_q    <= 1'b1;
        mdio_oe_q   <= 1'b1;
        rsp_rdata_q <= '0;
        rsp_err_q   <= 1'b0;
      end else if (mdc_fall) begin
        unique case (state_q)
          S_PREAMBLE: if (bit_cnt_q == 5'(PREAMBLE_LEN - 1)) begin
            mdio_o_q <= frame_q[31];
            frame_q  <= frame_q << 1;
          end
          S_FRAME: begin
            if (last_bit) begin
              mdio_o_q  <= 1'b1;
              mdio_oe_q <= 1'b0;
            end else begin
              mdio_o_q  <= frame_q[31];
              frame_q   <= frame_q << 1;
              // reads release the line from the first TA bit onward
              mdio_oe_q <= wr_q || (bit_cnt_q < 5'(TA_BIT0 - 1));
            end
          end
          S_TAIL: begin
            rsp_valid_q <= 1'b1;
            if (!wr_q) begin
              rsp_rdata_q <= rd_shift_q;
              rsp_err_q   <= ta_err_q;
            end
          end
          default: ;
        endcase
      end

      if (mdc_rise && state_q == S_FRAME && !wr_q) begin
        if (bit_cnt_q == 5'(TA_BIT0 + 1)) ta_err_q <= mdio_i;
        if (bit_cnt_q >= 5'(DATA_BIT0))   rd_shift_q <= {rd_shift_q[14:0], mdio_i};
      end
    end
  end

  assign strap_out = STRAP_VAL;
  assign mdio_o    = mdio_o_q;
  assign mdio_oe   = mdio_oe_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: doc/phy_mgmt_ctrl.md
PHY_MGMT_CTRL -- requirements
Module: phy_mgmt_ctrl

Interface
REQ-001 SHALL have parameter CLK_DIV, default 10; clk_50 cycles per MDC half-period (2.5 MHz MDC).
REQ-002 SHALL have parameter RST_CYCLES, default 500000; clk_50 cycles phy_hw_rst is held low (10 ms).
REQ-003 SHALL have parameter STRAP_HOLD, default 50; clk_50 cycles the straps are held after phy_hw_rst rises.
REQ-004 SHALL have parameter STRAP_VAL, default 8'h00; configuration-mode value driven on gm_rxd during reset.
REQ-005 SHALL have parameter PHY_ADDR, default 5'd0; MDIO PHY address.
REQ-006 SHALL have port clk_50  in  1  sole clock.
REQ-007 SHALL have port reset_n  in  1  asynchronous, active-low reset.
REQ-008 SHALL have port rst_req  in  1  one-cycle pulse requesting a PHY re-reset.
REQ-009 SHALL have port phy_hw_rst  out  1  PHY hardware reset; 0 = PHY in reset.
REQ-010 SHALL have ports strap_oe  out  1 and strap_out  out  8  drive enable and value for gm_rxd straps.
REQ-011 SHALL have ports req_valid in 1, req_ready out 1, req_write in 1, req_reg in 5, req_wdata in 16  management request.
REQ-012 SHALL have ports rsp_valid out 1, rsp_rdata out 16, rsp_err out 1  management response.
REQ-013 SHALL have ports mdc out 1, mdio_o out 1, mdio_oe out 1, mdio_i in 1  Clause 22 MDIO pins.
REQ-014 SHALL have port phy_ready  out  1  high while in IDLE.

Function
REQ-015 SHALL implement states RST_ASSERT, STRAP_HOLD, IDLE, PREAMBLE, FRAME, TAIL.
REQ-016 RST_ASSERT: phy_hw_rst=0, strap_oe=1, strap_out=STRAP_VAL; after RST_CYCLES cycles -> STRAP_HOLD.
REQ-017 STRAP_HOLD: phy_hw_rst=1, strap_oe=1; after STRAP_HOLD cycles strap_oe=0 and -> IDLE.
REQ-018 IDLE: req_ready=1, phy_ready=1, mdc=0, mdio_oe=0; req_ready=0 in every other state.
REQ-019 Request accepted on req_valid&&req_ready; req_write, req_reg, req_wdata latched that cycle; -> PREAMBLE.
REQ-020 rst_req in IDLE -> RST_ASSERT; rst_req in any other state ignored; rst_req and req_valid together in IDLE: rst_req wins, request not accepted.
REQ-021 mdc toggles every CLK_DIV cycles from PREAMBLE entry, starting low; mdio_o/mdio_oe change only on the clk_50 edge where mdc falls (first bit at PREAMBLE entry); mdio_i sampled on the edge where mdc rises.
REQ-022 PREAMBLE: 32 MDC periods, mdio_oe=1, mdio_o=1.
REQ-023 FRAME: 32 MDC periods, MSB first: ST=01, OP (01 write, 10 read), PHY_ADDR, req_reg, TA, 16 data bits.
REQ-024 Write: TA=10 and data=req_wdata, all with mdio_oe=1.
REQ-025 Read: mdio_oe=0 from first TA bit through last data bit; mdio_i at second TA bit sampled, 1 sets rsp_err; 16 data bits shifted into rsp_rdata MSB first.
REQ-026 TAIL: one MDC period, mdio_oe=0; then rsp_valid=1 for exactly one cycle, mdc=0, -> IDLE.
REQ-027 Latency: rsp_valid asserts exactly 65*2*CLK_DIV cycles after the accept cycle (1300 at default).
REQ-028 rsp_rdata, rsp_err hold until next accept; writes return rsp_rdata=0, rsp_err=0.
REQ-029 Counters SHALL be sized for their parameter maximum; no wrap within any state.

Reset
REQ-030 reset_n low SHALL immediately force: state RST_ASSERT, phy_hw_rst=0, strap_oe=1, strap_out=STRAP_VAL, mdc=0, mdio_o=1, mdio_oe=0, req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, phy_ready=0, all counters 0.
REQ-031 reset_n asserted mid-frame SHALL abort the frame with no rsp_valid; sequencing restarts at RST_ASSERT on release.

Structure
REQ-032 Shared package gige_pkg SHALL hold MDIO ST/OP constants, preamble length 32, frame length 32, and the state enum.
REQ-033 MDC half-period divider SHALL be a sub-module mdio_clk_gen producing rise/fall strobes and mdc.

Verification
REQ-034 Release reset (RST_CYCLES=100, STRAP_HOLD=10) -> phy_hw_rst low 100 cycles, strap_oe high 10 further cycles, phy_ready at cycle 110.
REQ-035 Write reg 0 = 16'h1140 (PHY_ADDR=1) -> mdio bits 32x1, 0101 00001 00000 10 0001000101000000; rsp_valid at cycle 1300.
REQ-036 Read reg 2, model drives TA 0 then 16'h0141 -> rsp_rdata=16'h0141, rsp_err=0, mdio_oe=0 during TA+data.
REQ-037 Read with mdio_i held 1 -> rsp_rdata=16'hFFFF, rsp_err=1.
REQ-038 rst_req with req_valid in IDLE -> request not accepted, phy_hw_rst=0 next cycle; rst_req mid-frame ignored.
REQ-039 reset_n low at frame bit 40 -> mdio_oe=0, mdc=0 immediately, no rsp_valid.
